// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the bit-counter width function.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A one-bit operand still needs a one-bit counter.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder: the only arithmetic element of the serial adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single fa_cell.
// The result is presented with a one-cycle done pulse WIDTH cycles after start.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_start,
   input  logic             in_sub,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_carry,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             sub_r;
   logic             c_r;
   logic             carry_r;
   logic             ovf_r;
   logic             last_bit;
   logic             accept;
   logic             a_bit;
   logic             b_bit;
   logic             fa_s;
   logic             fa_cout;

   assign last_bit = (cnt == CW'(WIDTH - 1));
   assign accept   = in_start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_start) state_nx = RUN;
         RUN:     if (last_bit) state_nx = DONE;
         DONE:    state_nx = in_start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Operand bits are selected by compare rather than a variable index so
   // that WIDTH=1 needs no special case.
   always_comb begin
      a_bit = 1'b0;
      b_bit = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (cnt == CW'(i)) begin
            a_bit = a_r[i];
            b_bit = b_r[i];
         end
      end
   end

   fa_cell u_fa (
      .a    (a_bit),
      .b    (b_bit ^ sub_r),
      .cin  (c_r),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // Subtract is a + ~b + ~borrow_in, so the carry register starts inverted.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         a_r     <= '0;
         b_r     <= '0;
         sub_r   <= 1'b0;
         c_r     <= 1'b0;
         cnt     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept) begin
         a_r   <= in_a;
         b_r   <= in_b;
         sub_r <= in_sub;
         c_r   <= in_carry ^ in_sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i)) sum_r[i] <= fa_s;
         end
         c_r <= fa_cout;
         cnt <= last_bit ? '0 : cnt + CW'(1);
         if (last_bit) begin
            carry_r <= fa_cout;
            ovf_r   <= c_r ^ fa_cout;
         end
      end
   end

   assign sum      = sum_r;
   assign carry    = carry_r;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected results come from integer arithmetic on the operands.
module tb_serial_adder;

   logic in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   int cyc = 0;
   always @(posedge in_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] sum;
      logic        carry;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q1[$];
   exp_t last8;

   logic       rst8, start8, sub8, cin8;
   logic [7:0] a8, b8;
   logic       busy8, done8, carry8, ovf8;
   logic [7:0] sum8;

   logic       rst1, start1, sub1, cin1;
   logic [0:0] a1, b1;
   logic       busy1, done1, carry1, ovf1;
   logic [0:0] sum1;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .in_clk   (in_clk),
      .in_rst   (rst8),
      .in_start (start8),
      .in_sub   (sub8),
      .in_a     (a8),
      .in_b     (b8),
      .in_carry (cin8),
      .busy     (busy8),
      .done     (done8),
      .sum      (sum8),
      .carry    (carry8),
      .overflow (ovf8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .in_clk   (in_clk),
      .in_rst   (rst1),
      .in_start (start1),
      .in_sub   (sub1),
      .in_a     (a1),
      .in_b     (b1),
      .in_carry (cin1),
      .busy     (busy1),
      .done     (done1),
      .sum      (sum1),
      .carry    (carry1),
      .overflow (ovf1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer add/subtract, signed range test for overflow.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic cin, input int done_cyc);
      longint m  = longint'(1) << w;
      longint ua = longint'(a) & (m - 1);
      longint ub = longint'(b) & (m - 1);
      longint ci = longint'(cin);
      longint r;
      longint sa;
      longint sb;
      longint sr;
      exp_t   e;
      r  = sub ? (ua - ub - ci) : (ua + ub + ci);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      sr = sub ? (sa - sb - ci) : (sa + sb + ci);
      e.sum   = 64'(r & (m - 1));
      e.carry = sub ? (r >= 0) : (r >= m);
      e.ovf   = (sr < -(m / 2)) || (sr > (m / 2) - 1);
      e.cyc   = done_cyc;
      return e;
   endfunction

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic cin, input bit push);
      a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      if (push) begin
         last8 = model(8, 64'(a), 64'(b), sub, cin, cyc + 8);
         q8.push_back(last8);
      end
   endtask

   task automatic go1(input logic a, input logic b, input logic sub, input logic cin);
      a1 = a; b1 = b; sub1 = sub; cin1 = cin; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      q1.push_back(model(1, 64'(a), 64'(b), sub, cin, cyc + 1));
   endtask

   int   busy_len8 = 0;
   logic prev_done8 = 1'b0;
   always @(negedge in_clk) begin
      if (rst8) begin
         busy_len8 = 0;
      end else begin
         if (busy8) busy_len8++;
         if (done8) begin
            exp_t e;
            chk("done_pulse8", 64'(prev_done8), 64'(0));
            chk("done_expected8", 64'(q8.size() != 0), 64'(1));
            if (q8.size() != 0) begin
               e = q8.pop_front();
               chk("sum8", 64'(sum8), e.sum);
               chk("carry8", 64'(carry8), 64'(e.carry));
               chk("ovf8", 64'(ovf8), 64'(e.ovf));
               chk("done_cycle8", 64'(cyc), 64'(e.cyc));
               chk("busy_len8", 64'(busy_len8), 64'(8));
            end
            busy_len8 = 0;
         end
         prev_done8 = done8;
      end
   end

   int   busy_len1 = 0;
   logic prev_done1 = 1'b0;
   always @(negedge in_clk) begin
      if (rst1) begin
         busy_len1 = 0;
      end else begin
         if (busy1) busy_len1++;
         if (done1) begin
            exp_t e;
            chk("done_pulse1", 64'(prev_done1), 64'(0));
            chk("done_expected1", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) begin
               e = q1.pop_front();
               chk("sum1", 64'(sum1), e.sum);
               chk("carry1", 64'(carry1), 64'(e.carry));
               chk("ovf1", 64'(ovf1), 64'(e.ovf));
               chk("done_cycle1", 64'(cyc), 64'(e.cyc));
               chk("busy_len1", 64'(busy_len1), 64'(1));
            end
            busy_len1 = 0;
         end
         prev_done1 = done1;
      end
   end

   initial begin
      rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
      rst1 = 1'b1; start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) tick();
      rst8 = 1'b0;
      rst1 = 1'b0;

      chk("rst_busy8", 64'(busy8), 64'(0));
      chk("rst_done8", 64'(done8), 64'(0));
      chk("rst_sum8", 64'(sum8), 64'(0));
      chk("rst_carry8", 64'(carry8), 64'(0));
      chk("rst_ovf8", 64'(ovf8), 64'(0));
      chk("rst_busy1", 64'(busy1), 64'(0));
      chk("rst_sum1", 64'(sum1), 64'(0));

      // Directed corner cases; each op lands in DONE so the next is back-to-back.
      go8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1); repeat (8) tick();
      tick();
      chk("hold_sum8", 64'(sum8), last8.sum);
      chk("hold_carry8", 64'(carry8), 64'(last8.carry));
      go8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1); repeat (8) tick();
      go8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1); repeat (8) tick();
      go8(8'h05, 8'h07, 1'b1, 1'b0, 1'b1); repeat (8) tick();
      go8(8'h80, 8'h01, 1'b1, 1'b0, 1'b1); repeat (8) tick();
      go8(8'h33, 8'h44, 1'b1, 1'b1, 1'b1); repeat (8) tick();
      tick();

      // Start during RUN must be ignored.
      go8(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
      repeat (2) tick();
      a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (5) tick();
      tick();

      // Reset mid-operation aborts with no done pulse.
      go8(8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      rst8 = 1'b1;
      tick();
      rst8 = 1'b0;
      chk("abort_busy8", 64'(busy8), 64'(0));
      chk("abort_done8", 64'(done8), 64'(0));
      chk("abort_sum8", 64'(sum8), 64'(0));
      chk("abort_carry8", 64'(carry8), 64'(0));
      go8(8'h01, 8'h02, 1'b0, 1'b1, 1'b1); repeat (8) tick();
      tick();

      for (int i = 0; i < 40; i++) begin
         go8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         repeat (8) tick();
         repeat ($urandom_range(0, 2)) tick();
      end

      // in_start held high across DONE: one op every 9 cycles.
      start8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
         tick();
         q8.push_back(model(8, 64'(a8), 64'(b8), sub8, cin8, cyc + 8));
         repeat (8) tick();
      end
      start8 = 1'b0;
      tick();

      go1(1'b1, 1'b1, 1'b0, 1'b0); tick();
      for (int i = 0; i < 20; i++) begin
         go1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tick();
         repeat ($urandom_range(0, 1)) tick();
      end

      repeat (4) tick();
      chk("q8_drained", 64'(q8.size()), 64'(0));
      chk("q1_drained", 64'(q1.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
